apb_crc_responder: RTL and testbench
====================================

// Module: apb_crc_responder
// PURPOSE
//  APB responder hosting a bit-serial CRC engine, the target side of the bus driven by the POLI master FSMs.
//  The master programs a polynomial, writes a data word and starts a run. It polls STATUS until done, then reads OUTPUT.
//  The block sits behind the POLI address decode as a stand-alone peripheral.
// PARAMETERS
//  WORD_SIZE   32            data/address width; CRC width equals WORD_SIZE
//  BASE_ADDR   32'h0000_0000 byte address of register 0
//  CRC_INIT    32'h0000_0000 value loaded into CRC on CONTROL.INIT
// PORTS
//  CLK      in   1          clock, all state on rising edge
//  RST      in   1          async active-high reset
//  PSEL     in   1          APB select
//  PENABLE  in   1          APB enable (access phase)
//  PWRITE   in   1          1=write, 0=read
//  PADDR    in   WORD_SIZE  byte address
//  PWDATA   in   WORD_SIZE  write data
//  PRDATA   out  WORD_SIZE  read data, valid while PREADY=1 on a read
//  PREADY   out  1          transfer may complete this cycle
//  PSLVERR  out  1          error response, valid with PREADY
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-high (CLK, RST).
//   - Asserting RST clears POLY, DATA, cnt, busy and done, and loads CRC to CRC_INIT.
//   - Outputs are combinational and read 0 while PSEL=0.
//   - RST asserted mid-run aborts the run; done stays 0.
//  Register map (offset from BASE_ADDR):
//   0x00 CONFIG  R/W  POLY
//   0x04 INPUT   R/W  DATA
//   0x08 CONTROL W    bit0 START, bit1 INIT; reads return 0
//   0x0C STATUS  R    bit0 done, bit1 busy, other bits 0
//   0x10 OUTPUT  R    CRC
//  APB handshake:
//   - PREADY = PSEL & ~stall. No other gating, so a master that ties PENABLE to PREADY also completes.
//   - stall = busy & PWRITE & (addr is CONFIG, INPUT or CONTROL). Reads never stall.
//   - Commit = PSEL & PENABLE & PREADY. Register writes take effect on that rising edge.
//   - A stalled write is held with PREADY=0 until busy falls, then commits.
//   - PRDATA = selected register when PSEL & ~PWRITE, else 0.
//  PSLVERR is 1 with PREADY when:
//   - the address is unmapped or misaligned (PADDR[1:0]!=0), or
//   - the transfer is a write to STATUS or OUTPUT.
//   Such transfers change no state and read 0.
//  Engine FSM:
//   - IDLE: a CONTROL commit with START=1 goes to RUN. On that edge: shift<=DATA, cnt<=0, busy<=1, done<=0.
//     If INIT=1 the same edge also sets CRC<=CRC_INIT before the run.
//   - INIT=1 with START=0: CRC<=CRC_INIT, done<=0, stay IDLE.
//   - START without INIT continues from the current CRC, which chains multi-word messages.
//   - RUN, once per cycle, MSB first:
//     fb = CRC[W-1] ^ shift[W-1]
//     CRC <= (CRC<<1) ^ (fb ? POLY : 0)
//     shift <= shift<<1, cnt++
//   - On the edge processing bit cnt=W-1: busy<=0, done<=1, return to IDLE.
//   - Latency: busy is high for exactly W cycles after the START commit edge. done reads 1 from the next cycle on.
//  done is sticky until the next START commit, INIT commit, or RST.
//  CONTROL write with START=0 and INIT=0 is a legal no-op.
//  Reads of OUTPUT while busy return the partial CRC, without error.
//  Back-to-back transfers with no idle cycle between them are legal.
// TESTING
//  Reset mid-run: START, then RST at cnt=10 -> busy=0, done=0, CRC=CRC_INIT, PRDATA=0.
//  Single word: CONFIG<=0xDEADBEEF, INPUT<=0x1, CONTROL<=0x3.
//   -> STATUS=0x2 for 32 cycles, then 0x1.
//   -> OUTPUT=0xDEADBEEF.
//  Zero data: INPUT<=0, CONTROL<=0x3 -> done after 32 cycles, OUTPUT=0x0.
//  Stall: write INPUT while busy -> PREADY=0 until busy falls, then commit.
//   -> DATA for the run in progress is unchanged.
//  Errors: read 0x14, write 0x0C, read 0x02 -> PSLVERR=1 with PREADY=1, PRDATA=0, no state change.
//  Chaining and poll: two words with START-only chaining -> OUTPUT matches the software bitwise model.
//   -> STATUS polled every cycle from an FSM master that ties PENABLE to PREADY sees done set exactly once.

Source files
------------

// File: rtl/apb_crc_responder.sv
// apb_crc_responder
//   APB target hosting a bit-serial CRC engine. The master programs a
//   polynomial (CONFIG), writes a data word (INPUT), starts a run through
//   CONTROL, polls STATUS until done, and then reads the result from OUTPUT.
//   The engine processes one data bit per clock, MSB first. A START without
//   INIT continues from the current CRC, so multi-word messages can be chained.
//
//   Register map (byte offsets from BASE_ADDR):
//     0x00 CONFIG  R/W  polynomial
//     0x04 INPUT   R/W  data word
//     0x08 CONTROL W    bit0 START, bit1 INIT (reads return 0)
//     0x0C STATUS  R    bit0 done, bit1 busy
//     0x10 OUTPUT  R    CRC (partial while busy)
//
// Ports
//   CLK      in   clock, all state on the rising edge
//   RST      in   asynchronous active-high reset
//   PSEL     in   APB select
//   PENABLE  in   APB access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address
//   PWDATA   in   write data
//   PRDATA   out  read data (0 unless PSEL and reading a valid register)
//   PREADY   out  transfer may complete this cycle
//   PSLVERR  out  error response, qualified by PREADY
module apb_crc_responder #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR = '0,
  parameter logic [WORD_SIZE-1:0] CRC_INIT  = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [WORD_SIZE-1:0] PADDR,
  input  logic [WORD_SIZE-1:0] PWDATA,
  output logic [WORD_SIZE-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR
);

  localparam int CNT_W = $clog2(WORD_SIZE);

  typedef enum logic [2:0] {
    REG_CONFIG, REG_INPUT, REG_CONTROL, REG_STATUS, REG_OUTPUT, REG_NONE
  } reg_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e               state, state_nxt;
  reg_e                 reg_sel;
  logic [WORD_SIZE-1:0] offset;
  logic [WORD_SIZE-1:0] poly, data, crc, shift, rd_val;
  logic [CNT_W-1:0]     cnt;
  logic                 done, busy, last_bit, fb;
  logic                 bad_addr, wr_to_ro, err, stall, commit, wr_en;
  logic                 start_cmd, init_cmd;

  // ---------------------------------------------------------------- decode
  assign offset = PADDR - BASE_ADDR;

  // Only the five word-aligned offsets are mapped; a misaligned address
  // (PADDR[1:0] != 0) or anything above 0x10 falls through to REG_NONE.
  // NOTE: every signal written in always_comb gets a default first, otherwise
  // paths that do not assign it would infer a latch.
  always_comb begin
    reg_sel = REG_NONE;
    if (offset[WORD_SIZE-1:5] == '0) begin
      case (offset[4:0])
        5'h00:   reg_sel = REG_CONFIG;
        5'h04:   reg_sel = REG_INPUT;
        5'h08:   reg_sel = REG_CONTROL;
        5'h0C:   reg_sel = REG_STATUS;
        5'h10:   reg_sel = REG_OUTPUT;
        default: reg_sel = REG_NONE;
      endcase
    end
  end

  assign busy     = (state == S_RUN);
  assign bad_addr = (reg_sel == REG_NONE);
  assign wr_to_ro = PWRITE && (reg_sel == REG_STATUS || reg_sel == REG_OUTPUT);
  assign err      = bad_addr || wr_to_ro;

  // Writes that could disturb the running engine are held off until it
  // finishes; reads never stall, so STATUS/OUTPUT polling always completes.
  assign stall = busy && PWRITE &&
                 (reg_sel == REG_CONFIG || reg_sel == REG_INPUT ||
                  reg_sel == REG_CONTROL);

  // PREADY deliberately ignores PENABLE so a master that ties PENABLE to
  // PREADY still completes its transfers.
  assign PREADY  = PSEL && !stall;
  assign PSLVERR = PREADY && err;
  assign commit  = PSEL && PENABLE && PREADY;
  assign wr_en   = commit && PWRITE && !err;

  assign start_cmd = wr_en && (reg_sel == REG_CONTROL) && PWDATA[0];
  assign init_cmd  = wr_en && (reg_sel == REG_CONTROL) && PWDATA[1];

  // ------------------------------------------------------------- read mux
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_CONFIG: rd_val = poly;
      REG_INPUT:  rd_val = data;
      REG_STATUS: rd_val = {{(WORD_SIZE-2){1'b0}}, busy, done};
      REG_OUTPUT: rd_val = crc;
      default:    rd_val = '0;
    endcase
  end

  assign PRDATA = (PSEL && !PWRITE) ? rd_val : '0;

  // ----------------------------------------------------------- engine FSM
  assign last_bit = busy && (cnt == CNT_W'(WORD_SIZE - 1));
  assign fb       = crc[WORD_SIZE-1] ^ shift[WORD_SIZE-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_cmd) state_nxt = S_RUN;
      S_RUN:   if (last_bit)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      poly  <= '0;
      data  <= '0;
      crc   <= CRC_INIT;
      shift <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      if (wr_en && reg_sel == REG_CONFIG) poly <= PWDATA;
      if (wr_en && reg_sel == REG_INPUT)  data <= PWDATA;

      if (state == S_IDLE) begin
        if (start_cmd) begin
          shift <= data;
          cnt   <= '0;
          done  <= 1'b0;
          if (PWDATA[1]) crc <= CRC_INIT;
        end else if (init_cmd) begin
          crc  <= CRC_INIT;
          done <= 1'b0;
        end
      end else begin
        crc   <= {crc[WORD_SIZE-2:0], 1'b0} ^ (fb ? poly : '0);
        shift <= {shift[WORD_SIZE-2:0], 1'b0};
        cnt   <= cnt + 1'b1;
        if (last_bit) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_crc_responder.sv
module tb_apb_crc_responder;

  localparam logic [31:0] A_CFG = 32'h00;
  localparam logic [31:0] A_IN  = 32'h04;
  localparam logic [31:0] A_CTL = 32'h08;
  localparam logic [31:0] A_ST  = 32'h0C;
  localparam logic [31:0] A_OUT = 32'h10;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PSEL = 1'b0, PWRITE = 1'b0, PENABLE;
  logic        penable_drv = 1'b0, tie_en = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  // A polling master may tie PENABLE to PREADY.
  assign PENABLE = tie_en ? PREADY : penable_drv;

  apb_crc_responder #(
    .WORD_SIZE(32), .BASE_ADDR(32'h0), .CRC_INIT(32'h0)
  ) dut (
    .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Software reference: bit-serial CRC, MSB first.
  function automatic logic [31:0] crc_model(input logic [31:0] crc_in,
                                            input logic [31:0] d,
                                            input logic [31:0] poly);
    logic [31:0] c;
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = (c << 1) ^ poly;
      else              c = c << 1;
    end
    return c;
  endfunction

  // One APB transfer: setup, access, wait (bounded) for PREADY, sample, commit.
  // PSEL stays high afterwards so consecutive calls are back-to-back.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int waited);
    @(negedge CLK);
    PSEL = 1'b1; PWRITE = wr; PADDR = addr; PWDATA = wdata; penable_drv = 1'b0;
    @(negedge CLK);
    penable_drv = 1'b1;
    waited = 0;
    while (PREADY !== 1'b1 && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    rdata = PRDATA;
    err   = PSLVERR;
    if (PREADY !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL pready_timeout addr=%h: PREADY=%b required 1", addr, PREADY);
    end
    @(posedge CLK);
    #1 penable_drv = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] r; logic e; int w;
    apb_xfer(1'b1, addr, wdata, r, e, w);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] rdata);
    logic e; int w;
    apb_xfer(1'b0, addr, 32'h0, rdata, e, w);
  endtask

  // Reads STATUS every cycle starting right after a START commit. Returns the
  // number of cycles STATUS read 0x2, the first other value, and how many
  // 0->1 transitions of done were seen over the run plus 8 further cycles.
  task automatic poll_status(input logic tie, output int busy_n,
                             output logic [31:0] st, output int rises);
    logic prev;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = A_ST;
    if (tie) tie_en = 1'b1; else penable_drv = 1'b1;
    busy_n = 0; rises = 0;
    @(negedge CLK);
    prev = PRDATA[0];
    while (PRDATA === 32'h2 && busy_n < 100) begin
      busy_n++;
      @(negedge CLK);
      if (PRDATA[0] && !prev) rises++;
      prev = PRDATA[0];
    end
    st = PRDATA;
    repeat (8) begin
      @(negedge CLK);
      if (PRDATA[0] && !prev) rises++;
      prev = PRDATA[0];
    end
    tie_en = 1'b0; penable_drv = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] addrs [5];
    logic [31:0] r;
    addrs = '{A_CFG, A_IN, A_CTL, A_ST, A_OUT};
    @(negedge CLK);
    n_cmp++;
    if ({PRDATA, PREADY, PSLVERR} !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_idle_outputs: got %h/%b/%b required 0/0/0", PRDATA, PREADY, PSLVERR);
    end
    @(negedge CLK) RST = 1'b0;
    foreach (addrs[i]) begin
      apb_read(addrs[i], r);
      n_cmp++;
      if (r !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_reg_%h: got %h required 00000000", addrs[i], r);
      end
    end
  endtask

  task automatic test_single_word;
    int b, rises; logic [31:0] st, r;
    apb_write(A_CFG, 32'hDEADBEEF);
    apb_write(A_IN, 32'h1);
    apb_write(A_CTL, 32'h3);
    poll_status(1'b0, b, st, rises);
    n_cmp++;
    if (b !== 32) begin n_bad++; $display("FAIL single_busy_cycles: got %0d required 32", b); end
    n_cmp++;
    if (st !== 32'h1) begin n_bad++; $display("FAIL single_status_done: got %h required 00000001", st); end
    apb_read(A_OUT, r);
    n_cmp++;
    if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_output: got %h required deadbeef", r); end
  endtask

  task automatic test_zero_data;
    int b, rises; logic [31:0] st, r;
    apb_write(A_IN, 32'h0);
    apb_write(A_CTL, 32'h3);
    poll_status(1'b0, b, st, rises);
    n_cmp++;
    if (b !== 32 || st !== 32'h1) begin
      n_bad++; $display("FAIL zero_timing: got busy=%0d status=%h required 32/00000001", b, st);
    end
    apb_read(A_OUT, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL zero_output: got %h required 00000000", r); end
  endtask

  task automatic test_stall;
    logic [31:0] r; logic e; int w;
    apb_write(A_IN, 32'h1);
    apb_write(A_CTL, 32'h3);
    // Access phase begins one cycle after the START commit, so 31 stalled
    // cycles remain of the 32-cycle run.
    apb_xfer(1'b1, A_IN, 32'hFFFFFFFF, r, e, w);
    n_cmp++;
    if (w !== 31 || e !== 1'b0) begin
      n_bad++; $display("FAIL stall_wait: got waited=%0d err=%b required 31/0", w, e);
    end
    apb_read(A_OUT, r);
    n_cmp++;
    if (r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stall_run_data: got %h required deadbeef", r); end
    apb_read(A_IN, r);
    n_cmp++;
    if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL stall_commit: got %h required ffffffff", r); end
  endtask

  task automatic test_errors;
    logic        wrs   [6];
    logic [31:0] addrs [6];
    logic [31:0] wds   [6];
    logic [31:0] chk_a [4];
    logic [31:0] chk_v [4];
    logic [31:0] r; logic e; int w;
    wrs   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    addrs = '{32'h14, A_ST, 32'h02, A_OUT, 32'h01, 32'h20};
    wds   = '{32'h0, 32'h3, 32'h0, 32'h5, 32'h1234, 32'h55};
    foreach (addrs[i]) begin
      apb_xfer(wrs[i], addrs[i], wds[i], r, e, w);
      n_cmp++;
      if (e !== 1'b1 || r !== 32'h0) begin
        n_bad++;
        $display("FAIL err_%0d addr=%h: got pslverr=%b prdata=%h required 1/00000000", i, addrs[i], e, r);
      end
    end
    chk_a = '{A_CFG, A_IN, A_ST, A_OUT};
    chk_v = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'h1, 32'hDEADBEEF};
    foreach (chk_a[i]) begin
      apb_read(chk_a[i], r);
      n_cmp++;
      if (r !== chk_v[i]) begin
        n_bad++; $display("FAIL err_nochange_%h: got %h required %h", chk_a[i], r, chk_v[i]);
      end
    end
  endtask

  task automatic test_control;
    logic [31:0] r;
    apb_read(A_CTL, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL ctl_read: got %h required 00000000", r); end
    apb_write(A_CTL, 32'h0);
    apb_read(A_ST, r);
    n_cmp++;
    if (r !== 32'h1) begin n_bad++; $display("FAIL ctl_noop: got %h required 00000001", r); end
    apb_write(A_CTL, 32'h2);
    apb_read(A_ST, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL init_clears_done: got %h required 00000000", r); end
    apb_read(A_OUT, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL init_crc: got %h required 00000000", r); end
  endtask

  task automatic test_chaining;
    logic [31:0] poly, w1, w2, exp_crc, st, r;
    int b, rises;
    poly = 32'h04C11DB7; w1 = 32'h12345678; w2 = 32'h9ABCDEF0;
    exp_crc = crc_model(crc_model(32'h0, w1, poly), w2, poly);
    apb_write(A_CFG, poly);
    apb_write(A_CTL, 32'h2);
    apb_write(A_IN, w1);
    apb_write(A_CTL, 32'h1);
    poll_status(1'b0, b, st, rises);
    apb_write(A_IN, w2);
    apb_write(A_CTL, 32'h1);
    poll_status(1'b1, b, st, rises);
    n_cmp++;
    if (b !== 32 || st !== 32'h1) begin
      n_bad++; $display("FAIL chain_poll: got busy=%0d status=%h required 32/00000001", b, st);
    end
    n_cmp++;
    if (rises !== 1) begin n_bad++; $display("FAIL chain_done_once: got %0d required 1", rises); end
    apb_read(A_OUT, r);
    n_cmp++;
    if (r !== exp_crc) begin n_bad++; $display("FAIL chain_output: got %h required %h", r, exp_crc); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r1, r2, r3;
    apb_write(A_CFG, 32'hA5A5A5A5);
    apb_write(A_IN, 32'h0F0F0F0F);
    apb_read(A_CFG, r1);
    apb_read(A_IN, r2);
    apb_read(A_ST, r3);
    n_cmp++;
    if (r1 !== 32'hA5A5A5A5 || r2 !== 32'h0F0F0F0F || r3 !== 32'h1) begin
      n_bad++;
      $display("FAIL b2b: got %h/%h/%h required a5a5a5a5/0f0f0f0f/00000001", r1, r2, r3);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] r;
    apb_write(A_CFG, 32'hDEADBEEF);
    apb_write(A_IN, 32'hFFFFFFFF);
    apb_write(A_CTL, 32'h3);
    repeat (10) @(posedge CLK);   // cnt == 10 after the tenth RUN edge
    #1 RST = 1'b1;
    PSEL = 1'b0; PWRITE = 1'b0; PADDR = A_OUT;
    #1;
    n_cmp++;
    if (PRDATA !== 32'h0) begin n_bad++; $display("FAIL rst_prdata_idle: got %h required 00000000", PRDATA); end
    PSEL = 1'b1; PADDR = A_ST;
    #1;
    n_cmp++;
    if (PRDATA !== 32'h0) begin n_bad++; $display("FAIL rst_status: got %h required 00000000", PRDATA); end
    PADDR = A_OUT;
    #1;
    n_cmp++;
    if (PRDATA !== 32'h0) begin n_bad++; $display("FAIL rst_crc: got %h required 00000000", PRDATA); end
    PSEL = 1'b0;
    @(negedge CLK) RST = 1'b0;
    repeat (3) @(negedge CLK);
    apb_read(A_ST, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL rst_no_resume: got %h required 00000000", r); end
    apb_read(A_CFG, r);
    n_cmp++;
    if (r !== 32'h0) begin n_bad++; $display("FAIL rst_poly: got %h required 00000000", r); end
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_zero_data;
    test_stall;
    test_errors;
    test_control;
    test_chaining;
    test_back_to_back;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
